// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking arbiter
// sharing one FIFO write port among NREQ requesters.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [DWIDTH-1:0]        fifo_din,
  output logic                     fifo_write,
  input  logic                     fifo_full,
  input  logic                     fifo_almost_full,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {ARB, GRANT} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     grant_nx;
  logic [IW-1:0]     pick;
  logic              found;
  logic [CW-1:0]     beat_cnt, beat_nx;
  logic              busy_nx;
  logic              term;
  logic [DWIDTH-1:0] owner_data;

  // grant_id doubles as owner and last_owner
  // round-robin search starting after last_owner
  always_comb begin : pick_p
    int            idx;
    logic [IW-1:0] ci;
    idx   = 0;
    ci    = '0;
    pick  = grant_id;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(grant_id) + k) % NREQ;
      ci  = IW'(idx);
      if (!found && req_valid[ci]) begin
        found = 1'b1;
        pick  = ci;
      end
    end
  end

  // data mux for the current owner
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == grant_id)
        owner_data = req_data[i*DWIDTH +: DWIDTH];
    end
  end

  // next-state and combinational outputs
  always_comb begin
    state_nx   = state;
    grant_nx   = grant_id;
    beat_nx    = beat_cnt;
    busy_nx    = busy;
    req_ready  = '0;
    fifo_write = 1'b0;
    fifo_din   = '0;
    term       = 1'b0;
    unique case (state)
      ARB: begin
        if (found && !fifo_almost_full) begin
          state_nx = GRANT;
          grant_nx = pick;
          beat_nx  = '0;
          busy_nx  = 1'b1;
        end
      end
      GRANT: begin
        req_ready[grant_id] = !fifo_full;
        fifo_write = req_valid[grant_id] & !fifo_full;
        fifo_din   = owner_data;
        if (fifo_write) begin
          beat_nx = beat_cnt + CW'(1);
          term    = req_last[grant_id] ||
                    (beat_cnt == CW'(MAX_BURST - 1));
          if (term) begin
            state_nx = ARB;
            busy_nx  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // state register, reset restarts search at requester 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      grant_id <= IW'(NREQ - 1);
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      grant_id <= grant_nx;
      beat_cnt <= beat_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench
// for the round-robin FIFO write arbiter.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MB   = 8;
  localparam int IW   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_last = '0;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      fifo_din;
  logic               fifo_write;
  logic               fifo_full = 1'b0;
  logic               fifo_almost_full = 1'b0;
  logic [IW-1:0]      grant_id;
  logic               busy;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DWIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .fifo_din(fifo_din), .fifo_write(fifo_write),
    .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW:0]   rq [NREQ][$];
  logic [DW-1:0] exp_q[$];
  int            wr_cyc[$];
  int            n_assert = 0;
  int            n_fail = 0;
  int            wr_cnt = 0;
  int            cyc = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic add(input int r, input int n,
                     input logic [DW-1:0] base,
                     input bit lst, input bit to_exp);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = base + DW'(k);
      rq[r].push_back({lst && (k == n - 1), d});
      if (to_exp) exp_q.push_back(d);
    end
  endtask

  task automatic drive();
    logic [DW:0] h;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        h = rq[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = h[DW];
        req_data[i*DW +: DW] = h[DW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic step();
    logic [NREQ-1:0] fire;
    @(negedge clk);
    fire = req_valid & req_ready;
    if (fifo_full)
      chk("full_block", {req_ready, fifo_write}, '0);
    if (fifo_write) begin
      chk("sb_nonempty", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0)
        chk("fifo_din", fifo_din, exp_q.pop_front());
      wr_cnt++;
      wr_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (fire[i]) void'(rq[i].pop_front());
    drive();
    cyc++;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((pending() > 0 || busy) && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 400), 1);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", grant_id, NREQ - 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_write", fifo_write, 0);
    chk("rst_din", fifo_din, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int w;
    int b;
    #2;
    do_reset();

    // single requester 2, 3-beat burst
    add(2, 3, 32'h0000_0010, 1, 1);
    drive();
    step();
    chk("t1_grant", grant_id, 2);
    chk("t1_busy", busy, 1);
    chk("t1_ready", req_ready, 4'b0100);
    b = wr_cyc.size();
    wait_idle("t1");
    chk("t1_busy_end", busy, 0);
    chk("t1_hold", grant_id, 2);
    chk("t1_nwr", wr_cyc.size() - b, 3);
    chk("t1_gap", wr_cyc[b+2] - wr_cyc[b], 2);

    // all requesters, 1-beat bursts from reset
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        add(i, 1, 32'h200 + 32'(i * 16 + r), 1, 1);
    drive();
    b = wr_cyc.size();
    wait_idle("t2");
    for (int k = 0; k < 7; k++)
      chk("t2_gap", wr_cyc[b+k+1] - wr_cyc[b+k], 2);

    // requester 1 streams 20 beats, requester 3 interleaves
    add(1, 20, 32'h100, 1, 0);
    add(3, 1, 32'h300, 1, 0);
    add(3, 1, 32'h301, 1, 0);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h100 + 32'(k));
    exp_q.push_back(32'h300);
    for (int k = 8; k < 16; k++) exp_q.push_back(32'h100 + 32'(k));
    exp_q.push_back(32'h301);
    for (int k = 16; k < 20; k++) exp_q.push_back(32'h100 + 32'(k));
    drive();
    b = wr_cyc.size();
    wait_idle("t3");
    chk("t3_chunk", wr_cyc[b+7] - wr_cyc[b], 7);
    chk("t3_split", wr_cyc[b+8] - wr_cyc[b+7], 2);

    // fifo_full pulse mid-burst
    add(0, 6, 32'h400, 1, 1);
    drive();
    step();
    step();
    step();
    w = wr_cnt;
    fifo_full = 1'b1;
    repeat (3) step();
    chk("t4_nowr", wr_cnt, w);
    fifo_full = 1'b0;
    step();
    chk("t4_resume", wr_cnt, w + 1);
    wait_idle("t4");

    // almost_full withholds grant, not a running burst
    fifo_almost_full = 1'b1;
    add(0, 4, 32'h500, 1, 1);
    drive();
    repeat (3) begin
      step();
      chk("t5_wait_busy", busy, 0);
      chk("t5_wait_rdy", req_ready, 0);
    end
    fifo_almost_full = 1'b0;
    step();
    chk("t5_grant", grant_id, 0);
    chk("t5_busy", busy, 1);
    step();
    fifo_almost_full = 1'b1;
    wait_idle("t5");
    fifo_almost_full = 1'b0;

    // async reset during beat 2 of a 5-beat burst
    add(1, 5, 32'h600, 1, 0);
    exp_q.push_back(32'h600);
    drive();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ready", req_ready, 0);
    chk("t6_write", fifo_write, 0);
    chk("t6_din", fifo_din, 0);
    chk("t6_busy", busy, 0);
    chk("t6_gid", grant_id, NREQ - 1);
    rq[1].delete();
    add(0, 1, 32'h700, 1, 1);
    add(3, 1, 32'h730, 1, 1);
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("t6_first", grant_id, 0);
    chk("t6_busy2", busy, 1);
    wait_idle("t6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
